mem_copy_dma: RTL and testbench

Word-copy bus initiator for the single-cycle ARM SoC. It drives the same data-memory interface that the CPU drives into dmem: we, a, wd, and a combinationally returned rd, with the write taking effect on posedge clk.
- On a start pulse it copies a block of 32-bit words from a source address to a destination address, one read and one write per word.
- An external arbiter shares the memory port with the CPU through a req/gnt handshake.

---
 rtl/mem_copy_dma.sv | 114 +++++++++++
 tb/tb_mem_copy_dma.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// Word-copy bus initiator: copies len 32-bit words from src_addr to dst_addr over
// the shared dmem port, one granted read then one granted write per word.
module mem_copy_dma #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_req,
    input  logic             mem_gnt,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      buf_q, buf_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        mem_a   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else if (len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        cnt_d   = len;
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                mem_req = 1'b1;
                mem_a   = src_q;
                if (mem_gnt) begin
                    buf_d   = mem_rd;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                // Write strobe is gated by the grant so it can never fire ungranted.
                mem_req = 1'b1;
                mem_a   = dst_q;
                mem_we  = mem_gnt;
                if (mem_gnt) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_wd = buf_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign err    = err_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma: table of copy requests with hand-computed
// latency/traffic expectations, plus reset-abort and address-wrap sequences.
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [7:0]  len = '0;
    logic        busy, done, err, mem_req, mem_we;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:255];
    logic [31:0] rd_addrs[$];
    int pass_cnt = 0, total = 0;
    int wr_cnt = 0, we_viol = 0, stab_err = 0;
    int m_done_at, m_done_n, m_busy, m_err, m_req;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_a = '0, prev_wd = '0;

    mem_copy_dma #(.LEN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[9:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[9:2]] = mem_wd;
            wr_cnt++;
        end
    end

    always @(negedge clk) begin
        if (mem_we && !mem_gnt) we_viol++;
        if (prev_stall && reset && (mem_a != prev_a || mem_wd != prev_wd)) stab_err++;
        if (mem_req && mem_gnt && !mem_we) rd_addrs.push_back(mem_a);
        prev_stall = reset && mem_req && !mem_gnt;
        prev_a     = mem_a;
        prev_wd    = mem_wd;
    end

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [7:0]  len;
        logic [3:0]  pat;      // grant sequence, MSB first, repeating
        logic        intf;     // fire a second start mid-transfer
        int          exp_done; // cycle after start edge with done=1 (0: none)
        int          exp_wr;
        int          exp_err;
        int          exp_req;
    } vec_t;

    function automatic logic [31:0] srcval(int j);
        return 32'h11 * (j + 1);
    endfunction

    function automatic logic [31:0] bg(int j);
        return 32'hB000_0000 | j;
    endfunction

    function automatic logic [31:0] rdmem(int idx);
        return mem[idx[7:0]];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        start = 1'b1; src_addr = v.src; dst_addr = v.dst; len = v.len;
        wr_cnt = 0;
        rd_addrs.delete();
        @(posedge clk);
        #1 start = 1'b0;
        m_done_at = 0; m_done_n = 0; m_busy = 0; m_err = 0; m_req = 0;
        for (int c = 1; c <= 40; c++) begin
            mem_gnt = v.pat[3 - ((c - 1) % 4)];
            if (v.intf && c == 3) begin
                start = 1'b1; src_addr = 32'h40; dst_addr = 32'h180; len = 8'd2;
            end
            if (v.intf && c == 4) start = 1'b0;
            @(negedge clk);
            if (done) begin
                m_done_n++;
                if (m_done_at == 0) m_done_at = c;
            end
            if (busy) m_busy++;
            if (err) m_err++;
            if (mem_req) m_req++;
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vecs[6];

    initial begin
        vec_t w;
        for (int i = 0; i < 256; i++) mem[i] = bg(i);
        for (int i = 0; i < 8; i++) mem[i] = srcval(i);
        mem[255] = 32'hCAFE_F00D;

        vecs[0] = '{32'h0, 32'h80,  8'd4, 4'b1111, 1'b0, 9,  4, 0, 8};
        vecs[1] = '{32'h0, 32'h80,  8'd0, 4'b1111, 1'b0, 1,  0, 0, 0};
        vecs[2] = '{32'h2, 32'h80,  8'd2, 4'b1111, 1'b0, 0,  0, 1, 0};
        vecs[3] = '{32'h0, 32'hC0,  8'd4, 4'b1001, 1'b0, 17, 4, 0, 16};
        vecs[4] = '{32'h0, 32'h140, 8'd4, 4'b1111, 1'b1, 9,  4, 0, 8};
        vecs[5] = '{32'h0, 32'h81,  8'd1, 4'b1111, 1'b0, 0,  0, 1, 0};

        #12;
        chk("rst_ctrl", {27'd0, busy, done, err, mem_req, mem_we}, 32'd0);
        chk("rst_a", mem_a, 32'd0);
        chk("rst_wd", mem_wd, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int n = 0; n < 6; n++) begin
            run_vec(vecs[n]);
            chki($sformatf("v%0d_done_at", n), m_done_at, vecs[n].exp_done);
            chki($sformatf("v%0d_done_n", n), m_done_n, (vecs[n].exp_done != 0) ? 1 : 0);
            chki($sformatf("v%0d_busy", n), m_busy, vecs[n].exp_done);
            chki($sformatf("v%0d_err", n), m_err, vecs[n].exp_err);
            chki($sformatf("v%0d_req", n), m_req, vecs[n].exp_req);
            chki($sformatf("v%0d_writes", n), wr_cnt, vecs[n].exp_wr);
            if (vecs[n].exp_wr > 0)
                for (int i = 0; i < int'(vecs[n].len); i++)
                    chk($sformatf("v%0d_data%0d", n, i),
                        rdmem(int'(vecs[n].dst[9:2]) + i),
                        srcval(int'(vecs[n].src[9:2]) + i));
            if (vecs[n].intf) chk($sformatf("v%0d_intf_dst", n), mem[96], bg(96));
        end
        chk("err_dst_kept0", mem[32], 32'h11);
        chk("err_dst_kept1", mem[33], 32'h22);

        // Reset asserted after the second write of an 8-word copy.
        @(negedge clk);
        start = 1'b1; src_addr = 32'h0; dst_addr = 32'h100; len = 8'd8;
        mem_gnt = 1'b1; wr_cnt = 0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_ctrl", {27'd0, busy, done, err, mem_req, mem_we}, 32'd0);
        chk("abort_a", mem_a, 32'd0);
        chk("abort_wd", mem_wd, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chki("abort_writes", wr_cnt, 2);
        chk("abort_w0", mem[64], 32'h11);
        chk("abort_w1", mem[65], 32'h22);
        chk("abort_w2", mem[66], bg(66));
        chk("abort_w7", mem[71], bg(71));
        @(negedge clk);
        reset = 1'b1;
        w = '{32'h10, 32'h100, 8'd4, 4'b1111, 1'b0, 9, 4, 0, 8};
        run_vec(w);
        chki("post_rst_done_at", m_done_at, 9);
        chki("post_rst_writes", wr_cnt, 4);
        chk("post_rst_w0", mem[64], 32'h55);
        chk("post_rst_w3", mem[67], 32'h88);

        // Source crossing the top of the address space wraps to zero.
        w = '{32'hFFFF_FFFC, 32'h200, 8'd2, 4'b1111, 1'b0, 5, 2, 0, 4};
        run_vec(w);
        chki("wrap_done_at", m_done_at, 5);
        chki("wrap_nreads", rd_addrs.size(), 2);
        if (rd_addrs.size() >= 2) begin
            chk("wrap_rd0", rd_addrs[0], 32'hFFFF_FFFC);
            chk("wrap_rd1", rd_addrs[1], 32'h0000_0000);
        end
        chk("wrap_w0", mem[128], 32'hCAFE_F00D);
        chk("wrap_w1", mem[129], 32'h11);

        chki("we_without_gnt", we_viol, 0);
        chki("stall_stability", stab_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
